adc_sample_sequencer: RTL and testbench



---
 rtl/adc_sample_sequencer_if.sv | 11 +
 rtl/adc_sample_sequencer.sv | 68 ++++++
 tb/tb_adc_sample_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if: control, ADC bus and register-file outputs of the sample sequencer
interface adc_sample_sequencer_if;
  logic        enable;
  logic [7:0]  JA;
  logic        ack;
  logic [31:0] adc_data;
  logic [31:0] adc_status;
  logic        sample_tick;
  modport master (output enable, JA, ack, input adc_data, adc_status, sample_tick);
  modport slave  (input enable, JA, ack, output adc_data, adc_status, sample_tick);
endinterface

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: periodic ADC capture, 2^AVG_LOG2 averaging, sticky ready/overrun handshake
module adc_sample_sequencer #(
  parameter int SAMPLE_PERIOD = 500,
  parameter int SETTLE        = 2,
  parameter int AVG_LOG2      = 3
) (
  input logic clock,
  input logic ctrl_reset,
  adc_sample_sequencer_if.slave bus
);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int NW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int AW = 8 + AVG_LOG2;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_PUBLISH} state_t;
  state_t state, state_n;
  logic [7:0] ja_s1, ja_s2, adc_avg;
  logic [PW-1:0] pcnt;
  logic [3:0] scnt;
  logic [NW-1:0] n;
  logic [AW-1:0] acc;
  logic adc_ready, overrun, tick, last, publish;
  assign tick = bus.enable && pcnt == PW'(SAMPLE_PERIOD - 1);
  assign last = n == NW'((1 << AVG_LOG2) - 1);
  assign publish = state == S_PUBLISH;
  assign bus.sample_tick = tick;
  assign bus.adc_data = {24'b0, adc_avg};
  assign bus.adc_status = {30'b0, overrun, adc_ready};
  always_ff @(posedge clock) state <= ctrl_reset ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (tick) state_n = S_SETTLE;
      S_SETTLE:  if (scnt == 4'(SETTLE - 1)) state_n = S_CAPTURE;
      S_CAPTURE: state_n = last ? S_PUBLISH : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end
  // ack coincident with a publish consumes the old result, so it cannot raise overrun
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ja_s1     <= '0;
      ja_s2     <= '0;
      pcnt      <= '0;
      scnt      <= '0;
      n         <= '0;
      acc       <= '0;
      adc_avg   <= '0;
      adc_ready <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ja_s1 <= bus.JA;
      ja_s2 <= ja_s1;
      if (bus.enable) pcnt <= tick ? '0 : pcnt + 1'b1;
      scnt <= state == S_SETTLE ? scnt + 1'b1 : '0;
      if (state == S_CAPTURE) begin
        acc <= acc + AW'(ja_s2);
        n   <= n + 1'b1;
      end
      if (publish) begin
        adc_avg <= acc[AVG_LOG2+7:AVG_LOG2];
        acc     <= '0;
        n       <= '0;
      end
      adc_ready <= publish | (adc_ready & ~bus.ack);
      overrun   <= publish ? overrun | (adc_ready & ~bus.ack) : overrun & ~bus.ack;
    end
  end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer: directed vector table, corner sequences and random run against an event-scheduled model
module tb_adc_sample_sequencer;
  localparam int P = 16, S = 2, L = 2;
  logic clock = 1'b0;
  logic ctrl_reset;
  adc_sample_sequencer_if bus();
  adc_sample_sequencer #(.SAMPLE_PERIOD(P), .SETTLE(S), .AVG_LOG2(L)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    int          len;
    bit          en;
    logic [7:0]  ja;
    bit          ack;
    logic [31:0] data;
    logic [31:0] status;
  } vec_t;
  vec_t tbl[11];
  int checks = 0, errors = 0, cyc = 0;
  bit last_tick;
  int ecount, pub_at;
  int cap_at[$];
  int samples[$];
  logic [7:0] pub_val, m_avg, j1, j2;
  bit m_rdy, m_ovr;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    ecount = 0;
    pub_at = -1;
    cap_at.delete();
    samples.delete();
    m_avg = 0;
    m_rdy = 0;
    m_ovr = 0;
    j1 = 0;
    j2 = 0;
  endtask
  // one clock cycle: drive inputs, compare against the model, advance the model across the edge
  task automatic step(input bit en, input logic [7:0] ja, input bit ack, input bit rst);
    bit tick;
    int sum;
    bus.enable = en;
    bus.JA = ja;
    bus.ack = ack;
    ctrl_reset = rst;
    #1;
    tick = en && (ecount % P == P - 1);
    last_tick = bus.sample_tick;
    check("tick", 32'(bus.sample_tick), 32'(tick));
    check("data", bus.adc_data, {24'b0, m_avg});
    check("status", bus.adc_status, {30'b0, m_ovr, m_rdy});
    if (rst) model_reset();
    else begin
      if (pub_at == cyc) begin
        m_ovr = m_ovr | (m_rdy & ~ack);
        m_rdy = 1;
        m_avg = pub_val;
      end else if (ack) begin
        m_rdy = 0;
        m_ovr = 0;
      end
      if (cap_at.size() > 0 && cap_at[0] == cyc) begin
        void'(cap_at.pop_front());
        samples.push_back(int'(j2));
        if (samples.size() == (1 << L)) begin
          sum = 0;
          foreach (samples[i]) sum += samples[i];
          pub_val = 8'(sum >> L);
          pub_at = cyc + 1;
          samples.delete();
        end
      end
      if (tick) cap_at.push_back(cyc + S + 1);
      if (en) ecount++;
      j2 = j1;
      j1 = ja;
    end
    @(posedge clock);
    #1;
    cyc = rst ? 0 : cyc + 1;
  endtask
  initial begin
    int gated, first_after;
    tbl[0]  = '{67, 1, 8'h80, 0, 32'h00, 32'h0};
    tbl[1]  = '{1,  1, 8'h80, 0, 32'h80, 32'h1};
    tbl[2]  = '{28, 1, 8'd10, 0, 32'h80, 32'h1};
    tbl[3]  = '{16, 1, 8'd20, 0, 32'h80, 32'h1};
    tbl[4]  = '{16, 1, 8'd30, 0, 32'h80, 32'h1};
    tbl[5]  = '{4,  1, 8'd41, 0, 32'd25, 32'h3};
    tbl[6]  = '{1,  1, 8'h40, 1, 32'd25, 32'h0};
    tbl[7]  = '{63, 1, 8'h40, 0, 32'h40, 32'h1};
    tbl[8]  = '{63, 1, 8'h40, 0, 32'h40, 32'h1};
    tbl[9]  = '{1,  1, 8'h40, 1, 32'h40, 32'h1};
    tbl[10] = '{1,  1, 8'h40, 1, 32'h40, 32'h0};
    bus.enable = 0;
    bus.JA = 0;
    bus.ack = 0;
    ctrl_reset = 1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    cyc = 0;
    check("reset_data", bus.adc_data, 32'h0);
    check("reset_status", bus.adc_status, 32'h0);
    check("reset_tick", 32'(bus.sample_tick), 32'h0);
    foreach (tbl[i]) begin
      repeat (tbl[i].len) step(tbl[i].en, tbl[i].ja, tbl[i].ack, 0);
      check($sformatf("vec%0d_data", i), bus.adc_data, tbl[i].data);
      check($sformatf("vec%0d_status", i), bus.adc_status, tbl[i].status);
    end
    while (cyc < 292) step(1, 8'h22, 0, 0);
    step(1, 8'h22, 0, 1);
    check("midavg_rst_data", bus.adc_data, 32'h0);
    check("midavg_rst_status", bus.adc_status, 32'h0);
    check("midavg_rst_tick", 32'(bus.sample_tick), 32'h0);
    repeat (67) step(1, 8'h22, 0, 0);
    check("midavg_early_status", bus.adc_status, 32'h0);
    step(1, 8'h22, 0, 0);
    check("midavg_fresh_data", bus.adc_data, 32'h22);
    check("midavg_fresh_status", bus.adc_status, 32'h1);
    step(1, 8'h30, 0, 1);
    gated = 0;
    first_after = -1;
    for (int i = 0; i < 109; i++) begin
      if (i == 107) begin
        check("gate_pre_data", bus.adc_data, 32'h0);
        check("gate_pre_status", bus.adc_status, 32'h0);
      end
      if (i == 108) begin
        check("gate_avg_data", bus.adc_data, 32'h48);
        check("gate_avg_status", bus.adc_status, 32'h1);
      end
      step(!(i >= 19 && i < 59), i < 59 ? 8'h30 : 8'h50, 0, 0);
      if (last_tick && i >= 19 && i < 59) gated++;
      if (last_tick && i >= 59 && first_after < 0) first_after = i;
    end
    check("gate_no_ticks", 32'(gated), 32'd0);
    check("gate_resume_tick", 32'(first_after), 32'd71);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 699) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
